// File: rtl/imm_gen_pipe.sv
// Pipelined RISC-V immediate generator: decodes a 32-bit instruction into an
// XLEN-wide immediate, format code and illegal flag behind a 2-entry skid buffer.
module imm_gen_pipe #(
  parameter int XLEN     = 32,
  parameter bit AUTO_SEL = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [2:0]      imm_sel,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt,
  output logic            illegal
);

  typedef enum logic [2:0] {
    FMT_I  = 3'b000,
    FMT_S  = 3'b001,
    FMT_B  = 3'b010,
    FMT_J  = 3'b011,
    FMT_U  = 3'b100,
    FMT_Z  = 3'b101,
    FMT_R6 = 3'b110,
    FMT_R7 = 3'b111
  } fmt_e;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            illegal;
  } res_t;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    logic [XLEN-1:0] r;
    r       = {XLEN{v[31]}};
    r[31:0] = v;
    return r;
  endfunction

  // ---------------------------------------------------------------- decode
  logic [2:0] auto_fmt;
  logic       auto_bad;
  logic [2:0] sel_fmt;
  logic       sel_bad;
  res_t       dec;

  // NOTE: every signal written in always_comb gets a default first so no
  // path through the case statements can infer a latch.
  always_comb begin
    auto_fmt = FMT_I;
    auto_bad = 1'b0;
    case (instr[6:0])
      7'b0010011, 7'b0000011, 7'b1100111: auto_fmt = FMT_I;
      7'b0100011:                         auto_fmt = FMT_S;
      7'b1100011:                         auto_fmt = FMT_B;
      7'b1101111:                         auto_fmt = FMT_J;
      7'b0110111, 7'b0010111:             auto_fmt = FMT_U;
      7'b1110011:                         auto_fmt = instr[14] ? FMT_Z : FMT_I;
      default:                            auto_bad = 1'b1;
    endcase
  end

  assign sel_fmt = AUTO_SEL ? auto_fmt : imm_sel;
  assign sel_bad = AUTO_SEL ? auto_bad : (imm_sel[2] & imm_sel[1]);

  always_comb begin
    dec.imm     = '0;
    dec.fmt     = sel_fmt;
    dec.illegal = sel_bad;
    if (!sel_bad) begin
      case (sel_fmt)
        FMT_I: dec.imm = sext32({{20{instr[31]}}, instr[31:20]});
        FMT_S: dec.imm = sext32({{20{instr[31]}}, instr[31:25], instr[11:7]});
        FMT_B: dec.imm = sext32({{19{instr[31]}}, instr[31], instr[7],
                                 instr[30:25], instr[11:8], 1'b0});
        FMT_J: dec.imm = sext32({{11{instr[31]}}, instr[31], instr[19:12],
                                 instr[20], instr[30:21], 1'b0});
        FMT_U: dec.imm = sext32({instr[31:12], 12'b0});
        FMT_Z: dec.imm[4:0] = instr[19:15];
        default: dec.imm = '0;
      endcase
    end
  end

  // ------------------------------------------------------------ skid buffer
  state_e state, state_nxt;
  res_t   or_q, sk_q;
  logic   accept, drain;
  logic   load_or, or_from_sk, load_sk;

  // State is a flop, so in_ready never sees out_ready combinationally.
  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;

  always_comb begin
    state_nxt  = state;
    load_or    = 1'b0;
    or_from_sk = 1'b0;
    load_sk    = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: if (accept) begin
          state_nxt = ONE;
          load_or   = 1'b1;
        end
        ONE: begin
          if (accept && drain) begin
            load_or = 1'b1;
          end else if (accept) begin
            state_nxt = TWO;
            load_sk   = 1'b1;
          end else if (drain) begin
            state_nxt = EMPTY;
          end
        end
        TWO: if (drain) begin
          state_nxt  = ONE;
          or_from_sk = 1'b1;
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= EMPTY;
    else        state <= state_nxt;
  end

  // NOTE: both data registers are reset because the outputs must read zero
  // during reset and a stale skid entry must never resurface afterwards.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      or_q <= '0;
      sk_q <= '0;
    end else begin
      if (load_or)         or_q <= dec;
      else if (or_from_sk) or_q <= sk_q;
      if (load_sk)         sk_q <= dec;
    end
  end

  assign imm     = or_q.imm;
  assign fmt     = or_q.fmt;
  assign illegal = or_q.illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: XLEN=32 auto, XLEN=64 auto and XLEN=32
// manual-select instances, each with its own expected-result queue.
module tb_imm_gen_pipe;

  typedef struct packed {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } exp_t;

  localparam logic [2:0] F_I = 3'b000, F_S = 3'b001, F_B = 3'b010,
                         F_J = 3'b011, F_U = 3'b100, F_Z = 3'b101;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid  [3];
  logic [31:0] instr     [3];
  logic [2:0]  imm_sel   [3];
  logic        in_ready  [3];
  logic        out_valid [3];
  logic        out_ready [3];
  logic [2:0]  fmt       [3];
  logic        illegal   [3];
  logic [31:0] imm_a, imm_m;
  logic [63:0] imm_w;
  logic [63:0] imm_x     [3];

  assign imm_x[0] = {32'b0, imm_a};
  assign imm_x[1] = imm_w;
  assign imm_x[2] = {32'b0, imm_m};

  exp_t q0[$], q1[$], q2[$];
  int checks   = 0;
  int failures = 0;

  imm_gen_pipe #(.XLEN(32), .AUTO_SEL(1'b1)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .instr(instr[0]),
    .imm_sel(imm_sel[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .imm(imm_a), .fmt(fmt[0]), .illegal(illegal[0]));

  imm_gen_pipe #(.XLEN(64), .AUTO_SEL(1'b1)) dut64 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .instr(instr[1]),
    .imm_sel(imm_sel[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .imm(imm_w), .fmt(fmt[1]), .illegal(illegal[1]));

  imm_gen_pipe #(.XLEN(32), .AUTO_SEL(1'b0)) dut_man (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]), .instr(instr[2]),
    .imm_sel(imm_sel[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .imm(imm_m), .fmt(fmt[2]), .illegal(illegal[2]));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per output handshake.
  always @(negedge clk) begin
    exp_t e;
    bit   have;
    for (int i = 0; i < 3; i++) begin
      if (reset && out_valid[i] && out_ready[i]) begin
        have = 1'b0;
        case (i)
          0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
          1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
          default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
        endcase
        if (!have) begin
          checks++;
          failures++;
          $display("FAIL dut%0d_unexpected_out actual imm=%h required no output", i, imm_x[i]);
        end else begin
          check($sformatf("dut%0d_imm", i), imm_x[i], e.imm);
          check($sformatf("dut%0d_fmt", i), {61'b0, fmt[i]}, {61'b0, e.fmt});
          check($sformatf("dut%0d_illegal", i), {63'b0, illegal[i]}, {63'b0, e.ill});
        end
      end
    end
  end

  // Drives one instruction until accepted; lat=1 also checks the 1-cycle latency.
  task automatic send(input int idx, input logic [31:0] ins, input logic [2:0] sel,
                      input exp_t e, input bit lat);
    bit acc;
    int n;
    acc = 1'b0;
    n   = 0;
    in_valid[idx] = 1'b1;
    instr[idx]    = ins;
    imm_sel[idx]  = sel;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready[idx];
      if (acc) begin
        case (idx)
          0: q0.push_back(e);
          1: q1.push_back(e);
          default: q2.push_back(e);
        endcase
      end
      @(posedge clk);
      #1;
      n++;
    end
    in_valid[idx] = 1'b0;
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL dut%0d_send_timeout actual in_ready=0 required 1", idx);
    end else if (lat) begin
      check($sformatf("dut%0d_latency_valid", idx), {63'b0, out_valid[idx]}, 64'd1);
      check($sformatf("dut%0d_latency_imm", idx), imm_x[idx], e.imm);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < 3; i++) in_valid[i] = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      in_valid[i]  = 1'b0;
      instr[i]     = '0;
      imm_sel[i]   = '0;
      out_ready[i] = 1'b1;
    end

    // Reset state
    #2;
    check("rst_out_valid", {63'b0, out_valid[0]}, 64'd0);
    check("rst_in_ready", {63'b0, in_ready[0]}, 64'd1);
    check("rst_imm", imm_x[0], 64'd0);
    check("rst_fmt_ill", {60'b0, fmt[0], illegal[0]}, 64'd0);
    check("rst_imm64", imm_x[1], 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // Back-to-back I/S/B, then J/U/Z and csrrw (I)
    send(0, 32'hFFF00093, 3'd0, {64'h0000_0000_FFFF_FFFF, F_I, 1'b0}, 1'b1);
    send(0, 32'hFE112E23, 3'd0, {64'h0000_0000_FFFF_FFFC, F_S, 1'b0}, 1'b1);
    send(0, 32'hFE000CE3, 3'd0, {64'h0000_0000_FFFF_FFF8, F_B, 1'b0}, 1'b1);
    send(0, 32'h0010006F, 3'd0, {64'h0000_0000_0000_0800, F_J, 1'b0}, 1'b1);
    send(0, 32'h123452B7, 3'd0, {64'h0000_0000_1234_5000, F_U, 1'b0}, 1'b1);
    send(0, 32'h00FFD073, 3'd0, {64'h0000_0000_0000_001F, F_Z, 1'b0}, 1'b1);
    send(0, 32'h00F01073, 3'd0, {64'h0000_0000_0000_000F, F_I, 1'b0}, 1'b1);
    send(0, 32'h0000007F, 3'd0, {64'h0, F_I, 1'b1}, 1'b1);
    idle(3);

    // XLEN=64
    send(1, 32'h800002B7, 3'd0, {64'hFFFF_FFFF_8000_0000, F_U, 1'b0}, 1'b1);
    send(1, 32'h0000007F, 3'd0, {64'h0, F_I, 1'b1}, 1'b1);
    send(1, 32'hFFF00093, 3'd0, {64'hFFFF_FFFF_FFFF_FFFF, F_I, 1'b0}, 1'b1);
    send(1, 32'hFE000CE3, 3'd0, {64'hFFFF_FFFF_FFFF_FFF8, F_B, 1'b0}, 1'b1);
    idle(3);

    // Manual select
    send(2, 32'hFFF00093, 3'b110, {64'h0, 3'b110, 1'b1}, 1'b1);
    send(2, 32'h123452B7, 3'b111, {64'h0, 3'b111, 1'b1}, 1'b1);
    send(2, 32'h123452B7, 3'b000, {64'h0000_0000_0000_0123, F_I, 1'b0}, 1'b1);
    send(2, 32'h00FFD073, 3'b101, {64'h0000_0000_0000_001F, F_Z, 1'b0}, 1'b1);
    idle(3);

    // Stall: two accepted, third held off until the first drain
    out_ready[0] = 1'b0;
    send(0, 32'h00500093, 3'd0, {64'h0000_0000_0000_0005, F_I, 1'b0}, 1'b1);
    send(0, 32'h123452B7, 3'd0, {64'h0000_0000_1234_5000, F_U, 1'b0}, 1'b0);
    check("stall_in_ready", {63'b0, in_ready[0]}, 64'd0);
    in_valid[0] = 1'b1;
    instr[0]    = 32'hFE112E23;
    @(posedge clk); #1;
    check("stall_hold_ready", {63'b0, in_ready[0]}, 64'd0);
    check("stall_hold_imm", imm_x[0], 64'h5);
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    check("ready_after_drain", {63'b0, in_ready[0]}, 64'd1);
    send(0, 32'hFE112E23, 3'd0, {64'h0000_0000_FFFF_FFFC, F_S, 1'b0}, 1'b0);
    idle(3);

    // Flush in TWO with in_valid high
    out_ready[0] = 1'b0;
    send(0, 32'hFFF00093, 3'd0, {64'h0000_0000_FFFF_FFFF, F_I, 1'b0}, 1'b1);
    send(0, 32'h0010006F, 3'd0, {64'h0000_0000_0000_0800, F_J, 1'b0}, 1'b0);
    in_valid[0] = 1'b1;
    instr[0]    = 32'h00500093;
    flush       = 1'b1;
    @(posedge clk); #1;
    flush       = 1'b0;
    in_valid[0] = 1'b0;
    check("flush2_out_valid", {63'b0, out_valid[0]}, 64'd0);
    check("flush2_in_ready", {63'b0, in_ready[0]}, 64'd1);
    q0.delete();
    out_ready[0] = 1'b1;
    idle(3);

    // Flush in ONE while an accept happens: the accept is discarded
    out_ready[0] = 1'b0;
    send(0, 32'hFFF00093, 3'd0, {64'h0000_0000_FFFF_FFFF, F_I, 1'b0}, 1'b1);
    in_valid[0] = 1'b1;
    instr[0]    = 32'h00500093;
    flush       = 1'b1;
    @(posedge clk); #1;
    flush       = 1'b0;
    in_valid[0] = 1'b0;
    check("flush1_out_valid", {63'b0, out_valid[0]}, 64'd0);
    q0.delete();
    out_ready[0] = 1'b1;
    idle(3);

    // Asynchronous reset mid-stall in TWO
    out_ready[0] = 1'b0;
    send(0, 32'hFFF00093, 3'd0, {64'h0000_0000_FFFF_FFFF, F_I, 1'b0}, 1'b1);
    send(0, 32'h123452B7, 3'd0, {64'h0000_0000_1234_5000, F_U, 1'b0}, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check("arst_out_valid", {63'b0, out_valid[0]}, 64'd0);
    check("arst_in_ready", {63'b0, in_ready[0]}, 64'd1);
    check("arst_imm", imm_x[0], 64'd0);
    check("arst_fmt_ill", {60'b0, fmt[0], illegal[0]}, 64'd0);
    q0.delete();
    @(posedge clk); #1;
    reset        = 1'b1;
    out_ready[0] = 1'b1;
    send(0, 32'h0010006F, 3'd0, {64'h0000_0000_0000_0800, F_J, 1'b0}, 1'b1);
    idle(3);

    check("q0_drained", 64'(q0.size()), 64'd0);
    check("q1_drained", 64'(q1.size()), 64'd0);
    check("q2_drained", 64'(q2.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Parametrised, pipelined successor of the combinational immediate generator. Takes full 32-bit RISC-V instructions through a valid/ready input and produces the sign- or zero-extended immediate, its format code and an illegal flag through a registered valid/ready output.
- Sits between fetch/decode and execute in the pipelined core.
- Supports XLEN 32/64, the CSR zimm format, and opcode-based auto format selection.
- Includes a 2-entry skid buffer so that in_ready has no combinational path from out_ready.

Parameters:
- XLEN, 32, immediate output width; legal values 32 or 64.
- AUTO_SEL, 1. 1: format derived from opcode, imm_sel ignored. 0: format taken from imm_sel.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous pipeline flush, active high.
- in_valid  in  1  instr/imm_sel valid.
- in_ready  out  1  block can accept; registered.
- instr  in  32  full instruction word.
- imm_sel  in  3  format select when AUTO_SEL=0.
- out_valid  out  1  imm/fmt/illegal valid.
- out_ready  in  1  downstream accepts.
- imm  out  XLEN  generated immediate.
- fmt  out  3  resolved format code.
- illegal  out  1  unsupported format or opcode.

Behaviour:
- Format codes: I=000, S=001, B=010, J=011, U=100, Z=101. 110 and 111 are illegal.
- Immediate field mapping, with s = instr[31] replicated to XLEN:
  - I: s : instr[31:20].
  - S: s : instr[31:25], instr[11:7].
  - B: s : instr[31], instr[7], instr[30:25], instr[11:8], 0.
  - J: s : instr[31], instr[19:12], instr[20], instr[30:21], 0.
  - U: s above bit 31 : instr[31:12], 12'b0. For XLEN=64 the upper 32 bits are copies of instr[31].
  - Z: zero-extended instr[19:15].
- Auto decode on opcode instr[6:0]:
  - 0010011, 0000011, 1100111 -> I.
  - 0100011 -> S.
  - 1100011 -> B.
  - 1101111 -> J.
  - 0110111, 0010111 -> U.
  - 1110011 -> Z if instr[14]=1, else I.
  - Any other opcode -> fmt=I, imm=0, illegal=1.
- Manual select: imm_sel 110 or 111 -> fmt=imm_sel, imm=0, illegal=1.
- Storage: output register (OR) plus skid register (SK). States:
  - EMPTY: OR and SK empty.
  - ONE: OR full.
  - TWO: OR and SK full.
- Transfers: accept = in_valid & in_ready; drain = out_valid & out_ready.
- Transitions:
  - EMPTY + accept -> ONE (OR loaded).
  - ONE + accept & !drain -> TWO (SK loaded).
  - ONE + drain & !accept -> EMPTY.
  - ONE + accept & drain -> ONE (OR reloaded).
  - TWO + drain -> ONE (OR <= SK). in_ready=0 in TWO, so no accept occurs.
- Latency: exactly 1 cycle from accept to out_valid when the block is empty.
- Ordering: strict FIFO order, no drops, no duplicates.
- Output signals:
  - in_ready = (state != TWO), registered.
  - out_valid = (state != EMPTY).
  - imm/fmt/illegal hold stable while out_valid=1 and out_ready=0.
- Flush: next state EMPTY. An accept in the flush cycle is discarded; in_ready=1 the following cycle. Flush has priority over all other events.
- Reset (asynchronous, any time including mid-transfer):
  - State -> EMPTY.
  - out_valid=0, in_ready=1.
  - imm=0, fmt=000, illegal=0.
  - SK contents cleared.
- in_valid may be asserted with in_ready=0; the data is ignored until in_ready=1.

Test Plan:
- XLEN=32, AUTO_SEL=1, out_ready=1; send 0xFFF00093, 0xFE112E23, 0xFE000CE3 back-to-back -> one per cycle, each 1 cycle after accept: imm 0xFFFFFFFF/I, 0xFFFFFFFC/S, 0xFFFFFFF8/B; illegal=0.
- Send 0x0010006F, 0x123452B7, 0x00FFD073 (csrrwi, zimm=31) -> imm 0x00000800/J, 0x12345000/U, 0x0000001F/Z.
- XLEN=64: send 0x800002B7 -> imm 0xFFFFFFFF80000000, fmt U. Send opcode 0x0000007F -> imm 0, illegal=1.
- out_ready=0, in_valid held high with 3 distinct instrs -> first 2 accepted, then in_ready=0. Release out_ready -> all 3 emerge in order; in_ready returns 1 the cycle after the first drain.
- State TWO, pulse flush with in_valid=1 -> next cycle out_valid=0 and in_ready=1; the flush-cycle instr never appears on the output.
- Assert reset low mid-stall in TWO -> outputs go to 0 immediately (asynchronously), in_ready=1. After release, the first new instr appears 1 cycle after accept.
- AUTO_SEL=0, imm_sel=110 with any instr -> imm 0, fmt 110, illegal=1.
